// File: rtl/panel_driver_init.sv
// HUB75 driver-chip init: shifts two config words into every driver on the chain,
// then hands the bus back to the scanner. Optional macro: PANEL_INIT_AUTOSTART_EN.
module panel_driver_init #(
  parameter int          PIXELS_PER_ROW  = 64,
  parameter int          NUM_PANES       = 1,
  parameter logic [15:0] REG1_VALUE      = 16'h7FFF,
  parameter logic [15:0] REG2_VALUE      = 16'h0040,
  parameter int          REG1_LATCH_CLKS = 12,
  parameter int          REG2_LATCH_CLKS = 13,
  parameter int          GAP_CYCLES      = 4
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   mask_en,
  output logic                   output_enable_out,
  output logic                   pixel_clk_out,
  output logic                   latch_out,
  output logic [3*NUM_PANES-1:0] rgb1_out,
  output logic [3*NUM_PANES-1:0] rgb2_out
);

  localparam int PW = $clog2(PIXELS_PER_ROW);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS_PER_ROW - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SHIFT1, GAP, SHIFT2, DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pix, pix_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic          phase, phase_n;
  logic          done_n, go;
  logic          sh_n, pclk_n, latch_n, dbit_n, dbit;
  logic [15:0]   reg_n;
  int            lat_clks_n;

`ifdef PANEL_INIT_AUTOSTART_EN
  // Pending for exactly the first cycle after reset releases.
  logic auto_pend;
  always_ff @(posedge clk_in) begin
    if (reset) auto_pend <= 1'b1;
    else       auto_pend <= 1'b0;
  end
  assign go = start | auto_pend;
`else
  assign go = start;
`endif

  always_comb begin
    state_n = state;
    pix_n   = pix;
    phase_n = phase;
    gcnt_n  = gcnt;
    done_n  = done;
    unique case (state)
      IDLE: if (go) begin
        state_n = SHIFT1;
        pix_n   = '0;
        phase_n = 1'b0;
        done_n  = 1'b0;
      end
      SHIFT1, SHIFT2: begin
        phase_n = ~phase;
        if (phase) begin
          if (pix == PIX_LAST) begin
            pix_n   = '0;
            phase_n = 1'b0;
            gcnt_n  = '0;
            state_n = (state == SHIFT1) ? GAP : DONE;
          end else begin
            pix_n = pix + 1'b1;
          end
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) begin
          state_n = SHIFT2;
          pix_n   = '0;
          phase_n = 1'b0;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the pins are
  // glitch-free yet line up cycle-for-cycle with the state they describe.
  always_comb begin
    sh_n       = (state_n == SHIFT1) || (state_n == SHIFT2);
    reg_n      = (state_n == SHIFT2) ? REG2_VALUE : REG1_VALUE;
    lat_clks_n = (state_n == SHIFT2) ? REG2_LATCH_CLKS : REG1_LATCH_CLKS;
    pclk_n     = sh_n & phase_n;
    dbit_n     = sh_n & reg_n[~pix_n[3:0]];
    latch_n    = sh_n & (int'(pix_n) >= PIXELS_PER_ROW - lat_clks_n);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state         <= IDLE;
      pix           <= '0;
      phase         <= 1'b0;
      gcnt          <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      pixel_clk_out <= 1'b0;
      latch_out     <= 1'b0;
      dbit          <= 1'b0;
    end else begin
      state         <= state_n;
      pix           <= pix_n;
      phase         <= phase_n;
      gcnt          <= gcnt_n;
      done          <= done_n;
      busy          <= (state_n != IDLE);
      pixel_clk_out <= pclk_n;
      latch_out     <= latch_n;
      dbit          <= dbit_n;
    end
  end

  assign mask_en = busy;
  // Only observed while mask_en steers the bus here, so it stays blanked.
  assign output_enable_out = 1'b1;

  for (genvar i = 0; i < NUM_PANES; i++) begin : g_pane
    assign rgb1_out[3*i +: 3] = {3{dbit}};
    assign rgb2_out[3*i +: 3] = {3{dbit}};
  end

endmodule

// File: tb/tb_panel_driver_init.sv
// Bench for panel_driver_init: a per-cycle sequence model for two configurations
// plus literal pins on busy length, shifted data, latch windows and gap spacing.
module tb_panel_driver_init;

`ifdef PANEL_INIT_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int LEN_A = 4*64 + 4 + 1;
  localparam int LEN_B = 4*32 + 4 + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic       busy_a, done_a, mask_a, oe_a, pclk_a, latch_a;
  logic [2:0] rgb1_a, rgb2_a;
  logic       busy_b, done_b, mask_b, oe_b, pclk_b, latch_b;
  logic [5:0] rgb1_b, rgb2_b;

  panel_driver_init u_a (
    .clk_in(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
    .mask_en(mask_a), .output_enable_out(oe_a), .pixel_clk_out(pclk_a),
    .latch_out(latch_a), .rgb1_out(rgb1_a), .rgb2_out(rgb2_a));

  panel_driver_init #(.PIXELS_PER_ROW(32), .NUM_PANES(2)) u_b (
    .clk_in(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
    .mask_en(mask_b), .output_enable_out(oe_b), .pixel_clk_out(pclk_b),
    .latch_out(latch_b), .rgb1_out(rgb1_b), .rgb2_out(rgb2_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic busy, mask, oe, pclk, latch, dbit, done;
  } exp_t;

  // Output picture for sequence cycle k: 2 cycles per pixel, write, gap, write, done.
  function automatic exp_t model_out(bit act, int k, bit dn, int P, int G,
                                     int l1, int l2, logic [15:0] r1, logic [15:0] r2);
    exp_t e;
    int j, p, l;
    logic [15:0] r;
    bit sh;
    e = '{busy: act, mask: act, oe: 1'b1, pclk: 1'b0, latch: 1'b0, dbit: 1'b0, done: dn};
    sh = 1'b0; j = 0; l = 0; r = '0;
    if (act) begin
      if (k < 2*P) begin
        sh = 1'b1; j = k; r = r1; l = l1;
      end else if (k >= 2*P + G && k < 4*P + G) begin
        sh = 1'b1; j = k - 2*P - G; r = r2; l = l2;
      end
    end
    if (sh) begin
      p       = j / 2;
      e.pclk  = (j % 2) == 1;
      e.dbit  = r[15 - (p % 16)];
      e.latch = p >= P - l;
    end
    return e;
  endfunction

  // Sequence-level model: active flag, cycle index into the sequence, sticky done.
  bit armed = 1'b0;
  bit act_a = 1'b0, dn_a = 1'b0, ap_a = 1'b0;
  bit act_b = 1'b0, dn_b = 1'b0, ap_b = 1'b0;
  int k_a = 0, k_b = 0;

  always @(posedge clk) begin
    if (reset) begin
      armed = 1'b1;
      act_a = 1'b0; k_a = 0; dn_a = 1'b0; ap_a = AUTO;
      act_b = 1'b0; k_b = 0; dn_b = 1'b0; ap_b = AUTO;
    end else begin
      if (!act_a) begin
        if (start || ap_a) begin act_a = 1'b1; k_a = 0; dn_a = 1'b0; end
      end else if (k_a == LEN_A - 1) begin
        act_a = 1'b0; dn_a = 1'b1;
      end else k_a++;
      ap_a = 1'b0;
      if (!act_b) begin
        if (start || ap_b) begin act_b = 1'b1; k_b = 0; dn_b = 1'b0; end
      end else if (k_b == LEN_B - 1) begin
        act_b = 1'b0; dn_b = 1'b1;
      end else k_b++;
      ap_b = 1'b0;
    end
  end

  // Observation accumulators for DUT A (cleared by the main sequence).
  int           busy_cyc_a = 0, busy_cyc_b = 0, n_rise = 0, cyc = 0;
  int           rise_cyc [128];
  logic [127:0] data_vec = '0, latch_vec = '0;
  logic         prev_pclk = 1'b0;
  exp_t         ea, eb;

  always @(negedge clk) begin
    if (armed) begin
      ea = model_out(act_a, k_a, dn_a, 64, 4, 12, 13, 16'h7FFF, 16'h0040);
      chk("A_cycle", {busy_a, mask_a, oe_a, pclk_a, latch_a, done_a, rgb1_a, rgb2_a},
          {ea.busy, ea.mask, ea.oe, ea.pclk, ea.latch, ea.done, {3{ea.dbit}}, {3{ea.dbit}}});
      eb = model_out(act_b, k_b, dn_b, 32, 4, 12, 13, 16'h7FFF, 16'h0040);
      chk("B_cycle", {busy_b, mask_b, oe_b, pclk_b, latch_b, done_b, rgb1_b, rgb2_b},
          {eb.busy, eb.mask, eb.oe, eb.pclk, eb.latch, eb.done, {6{eb.dbit}}, {6{eb.dbit}}});
    end
    if (busy_a) busy_cyc_a++;
    if (busy_b) busy_cyc_b++;
    if (pclk_a && !prev_pclk && n_rise < 128) begin
      data_vec  = {data_vec[126:0], rgb1_a[0]};
      latch_vec = {latch_vec[126:0], latch_a};
      rise_cyc[n_rise] = cyc;
      n_rise++;
    end
    prev_pclk = pclk_a;
    cyc++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_acc();
    busy_cyc_a = 0; busy_cyc_b = 0; n_rise = 0;
    data_vec = '0; latch_vec = '0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done_a && n < 600) begin tick(); n++; end
    chk(nm, done_a, 1'b1);
  endtask

  initial begin
    // Run 1: reset, start, mid-busy start that must be ignored.
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    chk("rst_state_a", {busy_a, mask_a, done_a, oe_a, pclk_a, latch_a, rgb1_a, rgb2_a}, 12'b0001_0000_0000);
    chk("rst_state_b", {busy_b, done_b, pclk_b, latch_b, rgb1_b}, 10'b0);
    clear_acc();
    reset = 1'b0;
`ifdef PANEL_INIT_AUTOSTART_EN
    tick();
    chk("auto_busy_rise", busy_a, 1'b1);
`else
    tick();
    chk("idle_no_start", {busy_a, mask_a}, 2'b00);
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", {busy_a, mask_a}, 2'b11);
`endif
    repeat (19) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done("run1_done_timeout");
    chk("run1_busy_len_a", busy_cyc_a, 261);
    chk("run1_busy_len_b", busy_cyc_b, 133);
    chk("run1_pclk_rises", n_rise, 128);
    chk("reg_data", data_vec, {64'h7FFF_7FFF_7FFF_7FFF, 64'h0040_0040_0040_0040});
    chk("reg_latch", latch_vec, {64'h0000_0000_0000_0FFF, 64'h0000_0000_0000_1FFF});
    chk("gap_spacing", rise_cyc[64] - rise_cyc[63], 6);
    chk("rise_spacing", rise_cyc[1] - rise_cyc[0], 2);
    chk("done_sticky_b", done_b, 1'b1);

    // Run 2: start after done clears done and reruns the whole sequence.
    clear_acc();
    start = 1'b1; tick(); start = 1'b0;
    chk("rerun_done_clr", {busy_a, done_a, busy_b, done_b}, 4'b1010);
    wait_done("run2_done_timeout");
    chk("run2_busy_len_a", busy_cyc_a, 261);
    chk("run2_busy_len_b", busy_cyc_b, 133);
    chk("run2_pclk_rises", n_rise, 128);

    // Run 3: reset at cycle 50 with a coincident start; reset wins.
    start = 1'b1; tick(); start = 1'b0;
    repeat (49) tick();
    chk("mid_busy", busy_a, 1'b1);
    reset = 1'b1; start = 1'b1; tick();
    reset = 1'b0; start = 1'b0;
    chk("abort_a", {busy_a, mask_a, done_a, oe_a, pclk_a, latch_a, rgb1_a, rgb2_a}, 12'b0001_0000_0000);
    chk("abort_b", {busy_b, done_b, pclk_b, latch_b, rgb1_b, rgb2_b}, 16'b0);
    repeat (5) tick();
    chk("post_abort_busy", busy_a, AUTO);
    chk("post_abort_done", done_a, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/panel_driver_init.md
Name: panel_driver_init

Overview:
Parametrised successor to the fixed FM6126A init block. Shifts two programmable driver-chip configuration registers into every driver on a HUB75 chain. Latch length, chain width and pane count are configurable, with a start/busy/done handshake. Sits between reset release and the row scanner; while mask_en is high, the scanner's pixel/latch/OE drive is overridden.

Parameters:
PIXELS_PER_ROW, 64, shift clocks per register write (multiple of 16, >=16)
NUM_PANES, 1, parallel rgb1/rgb2 groups; each rgb port is 3*NUM_PANES bits
REG1_VALUE, 16'h7FFF, config word 1 (FM6126A reg 11)
REG2_VALUE, 16'h0040, config word 2 (FM6126A reg 12)
REG1_LATCH_CLKS, 12, trailing shift clocks with latch high during REG1 write
REG2_LATCH_CLKS, 13, trailing shift clocks with latch high during REG2 write
GAP_CYCLES, 4, idle clk_in cycles between the two writes (>=1)

Ports:
clk_in  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to run the init sequence
busy  output  1  high while the sequence runs
done  output  1  sticky high after completion; cleared by start or reset
mask_en  output  1  high whenever busy; scanner outputs must be muxed off
output_enable_out  output  1  active-low OE; held 1 (blank) while busy
pixel_clk_out  output  1  shift clock to drivers
latch_out  output  1  driver latch / LE
rgb1_out  output  3*NUM_PANES  serial config data, upper half
rgb2_out  output  3*NUM_PANES  serial config data, lower half

Behaviour:
- Reset (synchronous): state=IDLE; busy=0, done=0, mask_en=0, output_enable_out=1, pixel_clk_out=0, latch_out=0, rgb1_out=rgb2_out=0. Reset mid-sequence aborts on the next edge; no partial completion, done stays 0.
- States: IDLE -> SHIFT1 -> GAP -> SHIFT2 -> DONE -> IDLE.
- IDLE: start=1 -> SHIFT1 next cycle, pixel index p=0, phase=0. busy and mask_en go high on the same edge.
- SHIFT states: 2 clk_in cycles per pixel.
  - Phase 0: pixel_clk_out=0; rgb and latch updated.
  - Phase 1: pixel_clk_out=1; data and latch held stable.
  - Bit shifted for pixel p = REG[15 - (p mod 16)], MSB first, repeated every 16 pixels. Replicated to all 6*NUM_PANES rgb bits.
  - latch_out=1 iff p >= PIXELS_PER_ROW - REGn_LATCH_CLKS.
  - Leaving the state after p=PIXELS_PER_ROW-1, phase 1.
- GAP: GAP_CYCLES cycles with pixel_clk_out=0, latch_out=0, rgb=0.
- DONE: one cycle. Outputs idle, busy drops to 0, done set to 1; next cycle -> IDLE.
- Total busy duration: 4*PIXELS_PER_ROW + GAP_CYCLES + 1 cycles (261 at defaults).
- start while busy: ignored.
- start in IDLE with done=1: clears done and reruns.
- start coincident with reset: reset wins.
- Counters: pixel index width $clog2(PIXELS_PER_ROW); gap counter $clog2(GAP_CYCLES+1). No wrap-around beyond the terminal value.

Optional Feature:
PANEL_INIT_AUTOSTART_EN
- Defined: the block behaves as if start=1 on the first cycle after reset deasserts. The sequence runs with no external request; later start pulses still retrigger.
- Undefined: the sequence runs only on an explicit start pulse; after reset the block sits in IDLE with mask_en=0.

Test Plan:
- Defaults, no macro: reset 2 cycles, start pulse.
  - busy/mask_en high for exactly 261 cycles.
  - 128 rising edges of pixel_clk_out (64 per register).
  - done=1 from the cycle after busy falls.
- REG1 data/latch: sample rgb1_out[0] on each pixel_clk_out rise during SHIFT1.
  - Sequence is 0,1,1,...,1 (16-bit pattern 0x7FFF) repeated 4x.
  - latch_out high on exactly the last 12 rises.
- REG2: sample during SHIFT2.
  - Pattern 0x0040 (bit 6 set only) repeated 4x.
  - latch_out high on exactly the last 13 rises.
  - Exactly 4 idle cycles between SHIFT1 and SHIFT2.
- NUM_PANES=2, PIXELS_PER_ROW=32: all 6 bits of each rgb port equal the shifted bit. busy lasts 4*32+4+1=133 cycles.
- Reset at cycle 50 of the sequence: all outputs return to reset values next edge, done=0. A start pulse mid-busy (cycle 20) changes nothing.
- PANEL_INIT_AUTOSTART_EN defined: busy rises one cycle after reset deasserts with no start pulse. A second start after done reruns the full 261-cycle sequence.
